// File: rtl/printf_fetch_engine.sv
// Printf buffer fetch engine: reads a per-core buffer word by word, clears each
// word behind itself, and streams the bytes out until a terminator is seen.
module printf_fetch_engine #(
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  core_id_i,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_mask_o,
  input  logic        mem_gnt_i,
  input  logic [63:0] mem_rdata_i,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  output logic [1:0]  char_core_o,
  input  logic        char_ready_i,
  output logic        done_o
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned BYTES_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_CLR,
    EMIT,
    CLR_ONLY,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          base_q, base_d;
  logic [1:0]           core_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [63:0]          word_q, word_d;
  logic [BYTES_W-1:0]   bidx_q, bidx_d;
  logic                 term_q, term_d;

  logic                 busy_d, mem_req_d, mem_write_d, done_d;
  logic [31:0]          mem_addr_d;
  logic [7:0]           mem_mask_d;
  logic                 char_valid_d;
  logic [7:0]           char_data_d;
  logic [7:0]           cur_byte, next_byte;
  logic                 leave;

  // Byte b of a word, most significant byte first.
  function automatic logic [7:0] pick_byte(input logic [63:0] w, input logic [BYTES_W-1:0] b);
    return 8'(w >> {~b, 3'b000});
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  assign mem_wdata_o = 64'h0;

  // Next-state logic; outputs are decoded from the next state and registered.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    core_d    = char_core_o;
    idx_d     = idx_q;
    word_d    = word_q;
    bidx_d    = bidx_q;
    term_d    = term_q;
    leave     = 1'b0;
    cur_byte  = pick_byte(word_q, bidx_q);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = addr_i & ~32'h7;
          core_d  = core_id_i;
          idx_d   = '0;
          term_d  = 1'b0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        word_d  = mem_rdata_i;
        state_d = WR_CLR;
      end
      WR_CLR: begin
        if (mem_gnt_i) begin
          bidx_d  = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // A terminator consumes its cycle but is never handed to the consumer.
        if (is_term(cur_byte)) begin
          term_d = 1'b1;
          leave  = 1'b1;
        end else if (char_ready_i) begin
          if (bidx_q == BYTES_W'(7)) leave = 1'b1;
          else bidx_d = bidx_q + BYTES_W'(1);
        end
        if (leave) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = term_d ? CLR_ONLY : RD_REQ;
          end
        end
      end
      CLR_ONLY: begin
        if (mem_gnt_i) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d       = (state_d != IDLE);
    mem_req_d    = (state_d == RD_REQ) || (state_d == WR_CLR) || (state_d == CLR_ONLY);
    mem_write_d  = (state_d == WR_CLR) || (state_d == CLR_ONLY);
    mem_addr_d   = mem_req_d ? (base_d + 32'({idx_d, 3'b000})) : 32'h0;
    mem_mask_d   = mem_write_d ? 8'hFF : 8'h00;
    done_d       = (state_d == DONE);
    next_byte    = pick_byte(word_d, bidx_d);
    char_valid_d = (state_d == EMIT) && !is_term(next_byte);
    char_data_d  = char_valid_d ? next_byte : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= 32'h0;
      idx_q        <= '0;
      word_q       <= 64'h0;
      bidx_q       <= '0;
      term_q       <= 1'b0;
      busy_o       <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'h0;
      mem_mask_o   <= 8'h00;
      char_valid_o <= 1'b0;
      char_data_o  <= 8'h00;
      char_core_o  <= 2'b00;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      bidx_q       <= bidx_d;
      term_q       <= term_d;
      busy_o       <= busy_d;
      mem_req_o    <= mem_req_d;
      mem_write_o  <= mem_write_d;
      mem_addr_o   <= mem_addr_d;
      mem_mask_o   <= mem_mask_d;
      char_valid_o <= char_valid_d;
      char_data_o  <= char_data_d;
      char_core_o  <= core_d;
      done_o       <= done_d;
    end
  end

endmodule

// File: tb/tb_printf_fetch_engine.sv
// Randomized bench for printf_fetch_engine: a memory/consumer model responds to
// the DUT while a buffer-level reference predicts accesses, characters and timing.
module tb_printf_fetch_engine;

  localparam int NW = 16;

  logic        clk, rst, start_i;
  logic [31:0] addr_i;
  logic [1:0]  core_id_i;
  logic        busy_o, mem_req_o, mem_write_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_mask_o;
  logic        mem_gnt_i;
  logic [63:0] mem_rdata_i;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic [1:0]  char_core_o;
  logic        char_ready_i;
  logic        done_o;

  printf_fetch_engine #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .addr_i(addr_i), .core_id_i(core_id_i),
    .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_mask_o(mem_mask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i), .char_valid_o(char_valid_o),
    .char_data_o(char_data_o), .char_core_o(char_core_o), .char_ready_i(char_ready_i),
    .done_o(done_o)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
  } acc_t;

  logic [63:0] mem [logic [31:0]];
  acc_t        exp_acc[$];
  logic [7:0]  exp_chars[$];
  logic [7:0]  got_chars[$];
  logic [1:0]  exp_core;
  bit          done_allowed;
  int          n_checks, n_fail;
  int          n_reads, n_writes, n_chars, n_done, busy_cnt;
  logic [31:0] first_addr;
  bit          first_seen;
  int          gmode, rmode, stall_at;
  int          m_cyc, m_nch, m_nrd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [7:0] rand_char();
    logic [7:0] c;
    do c = 8'($urandom_range(1, 255)); while (c == 8'h0A || c == 8'h0D);
    return c;
  endfunction

  // Fill the buffer with printable-ish bytes; term_pos < 0 means no terminator.
  task automatic fill_buf(input logic [31:0] base, input int term_pos);
    logic [63:0] w;
    logic [7:0]  c;
    for (int i = 0; i < NW; i++) begin
      w = 64'h0;
      for (int b = 0; b < 8; b++) begin
        if (i * 8 + b == term_pos) begin
          case ($urandom_range(0, 2))
            0: c = 8'h00;
            1: c = 8'h0A;
            default: c = 8'h0D;
          endcase
        end else begin
          c = rand_char();
        end
        w = {w[55:0], c};
      end
      mem[base + 32'(i * 8)] = w;
    end
  endtask

  // Buffer-level reference: what must be read, cleared and printed, and how long it takes
  // when grant and ready never stall.
  task automatic build_model(input logic [31:0] base, output int cyc, output int nch, output int nrd);
    bit          term;
    logic [31:0] a;
    logic [63:0] w;
    logic [7:0]  c;
    exp_acc.delete();
    exp_chars.delete();
    term = 0; cyc = 1; nch = 0; nrd = 0;
    for (int i = 0; i < NW; i++) begin
      a = base + 32'(i * 8);
      if (term) begin
        exp_acc.push_back('{wr: 1'b1, addr: a});
        cyc++;
      end else begin
        exp_acc.push_back('{wr: 1'b0, addr: a});
        exp_acc.push_back('{wr: 1'b1, addr: a});
        nrd++;
        cyc += 3;
        w = mem_rd(a);
        for (int b = 0; b < 8 && !term; b++) begin
          c = w[63 - 8 * b -: 8];
          cyc++;
          if (c == 8'h00 || c == 8'h0A || c == 8'h0D) term = 1;
          else begin
            exp_chars.push_back(c);
            nch++;
          end
        end
      end
    end
  endtask

  task automatic clear_counters();
    n_reads = 0; n_writes = 0; n_chars = 0; n_done = 0; busy_cnt = 0;
    first_seen = 0; got_chars.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_mem_req"}, mem_req_o, 0);
    check({tag, "_mem_write"}, mem_write_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_mask"}, mem_mask_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_char_valid"}, char_valid_o, 0);
    check({tag, "_char_data"}, char_data_o, 0);
    check({tag, "_char_core"}, char_core_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  function automatic int nonzero_words(input logic [31:0] base);
    int n = 0;
    for (int i = 0; i < NW; i++) if (mem_rd(base + 32'(i * 8)) != 64'h0) n++;
    return n;
  endfunction

  task automatic run_job(input logic [31:0] a, input logic [1:0] core, input int gm, input int rm,
                         input bit spur, input int extra_cyc, input string tag);
    logic [31:0] base;
    int cyc;
    base = a & ~32'h7;
    build_model(base, m_cyc, m_nch, m_nrd);
    clear_counters();
    gmode = gm; rmode = rm; exp_core = core; done_allowed = 1;
    @(negedge clk);
    start_i = 1'b1; addr_i = a; core_id_i = core;
    @(negedge clk);
    start_i = 1'b0; addr_i = $urandom; core_id_i = 2'($urandom);
    cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start_i = spur && busy_o && ($urandom_range(0, 7) == 0);
      addr_i = $urandom;
    end
    start_i = 1'b0;
    check({tag, "_done_seen"}, n_done != 0, 1);
    repeat (3) @(negedge clk);
    done_allowed = 0;
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_acc_left"}, exp_acc.size(), 0);
    check({tag, "_chars_left"}, exp_chars.size(), 0);
    check({tag, "_n_chars"}, n_chars, m_nch);
    check({tag, "_n_reads"}, n_reads, m_nrd);
    check({tag, "_n_writes"}, n_writes, NW);
    check({tag, "_words_cleared"}, nonzero_words(base), 0);
    if (gm == 0 && rm == 0) check({tag, "_busy_cycles"}, busy_cnt, m_cyc + extra_cyc);
  endtask

  // Memory and consumer responder plus per-cycle output checker.
  initial begin
    bit          pend, last_rst, pv_valid, pv_ready, pq_req, pq_gnt, pq_wr;
    logic [31:0] paddr, pq_addr;
    logic [7:0]  pv_data;
    logic [63:0] w;
    acc_t        e;
    int          stall_left;
    bit          gnt, rdy;
    pend = 0; last_rst = 1; pv_valid = 0; pv_ready = 0; pq_req = 0; pq_gnt = 0; pq_wr = 0;
    paddr = 0; pq_addr = 0; pv_data = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      #1;
      mem_rdata_i = pend ? mem_rd(paddr) : {$urandom, $urandom};
      pend = 0;
      if (pv_valid && !pv_ready && !last_rst) begin
        check("char_valid_held", char_valid_o, 1);
        check("char_data_held", char_data_o, pv_data);
      end
      if (pq_req && !pq_gnt && !last_rst) begin
        check("mem_req_held", mem_req_o, 1);
        check("mem_addr_held", mem_addr_o, pq_addr);
        check("mem_write_held", mem_write_o, pq_wr);
      end
      if (rst) begin
        gnt = 0; rdy = 0;
      end else begin
        gnt = (gmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (stall_left > 0) begin
          rdy = 0; stall_left--;
        end else if (stall_at == 2 && char_valid_o && n_chars == 1) begin
          rdy = 0; stall_left = 4; stall_at = 0;
        end else begin
          rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
      mem_gnt_i = gnt;
      char_ready_i = rdy;
      if (!busy_o) check("idle_quiet", {mem_req_o, char_valid_o, done_o}, 0);
      if (mem_req_o) begin
        check("mem_addr_aligned", mem_addr_o[2:0], 0);
        check("req_exclusive", {done_o, char_valid_o}, 0);
        if (gnt) begin
          check("acc_expected", exp_acc.size() != 0, 1);
          if (exp_acc.size() != 0) begin
            e = exp_acc.pop_front();
            check("acc_write", mem_write_o, e.wr);
            check("acc_addr", mem_addr_o, e.addr);
          end
          if (!first_seen) begin
            first_seen = 1; first_addr = mem_addr_o;
          end
          if (mem_write_o) begin
            n_writes++;
            check("wr_mask", mem_mask_o, 8'hFF);
            check("wr_data", mem_wdata_o, 0);
            w = mem_rd(mem_addr_o);
            for (int b = 0; b < 8; b++) if (mem_mask_o[b]) w[8 * b +: 8] = mem_wdata_o[8 * b +: 8];
            mem[mem_addr_o] = w;
          end else begin
            n_reads++;
            pend = 1; paddr = mem_addr_o;
          end
        end
      end
      if (char_valid_o && rdy) begin
        n_chars++;
        got_chars.push_back(char_data_o);
        check("char_expected", exp_chars.size() != 0, 1);
        if (exp_chars.size() != 0) check("char_data", char_data_o, exp_chars.pop_front());
        check("char_core", char_core_o, exp_core);
      end
      if (done_o) begin
        n_done++;
        check("done_allowed", done_allowed, 1);
        check("done_acc_drained", exp_acc.size(), 0);
        check("done_chars_drained", exp_chars.size(), 0);
      end
      if (busy_o) busy_cnt++;
      pv_valid = char_valid_o; pv_ready = rdy; pv_data = char_data_o;
      pq_req = mem_req_o; pq_gnt = gnt; pq_wr = mem_write_o; pq_addr = mem_addr_o;
      last_rst = rst;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, a;
    logic [63:0] pre [NW];
    int cyc;
    n_checks = 0; n_fail = 0; stall_at = 0; gmode = 0; rmode = 0;
    done_allowed = 0; exp_core = 0;
    rst = 1'b1; start_i = 1'b0; addr_i = 0; core_id_i = 0;
    clear_counters();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // "Hi\n" then zeros, core 2.
    base = 32'h8000_1000;
    mem[base] = 64'h4869_0A00_0000_0000;
    for (int i = 1; i < NW; i++) mem[base + 32'(i * 8)] = 64'h0;
    run_job(base, 2'd2, 0, 0, 0, 0, "hi");
    check("hi_lit_nchars", got_chars.size(), 2);
    if (got_chars.size() == 2) begin
      check("hi_lit_c0", got_chars[0], 8'h48);
      check("hi_lit_c1", got_chars[1], 8'h69);
    end
    check("hi_lit_reads", n_reads, 1);
    check("hi_lit_writes", n_writes, 16);
    check("hi_lit_busy", busy_cnt, 22);

    // Unaligned start address.
    fill_buf(32'h8000_1000, 37);
    run_job(32'h8000_1005, 2'd1, 1, 1, 1, 0, "unal");
    check("unal_lit_first_addr", first_addr, 32'h8000_1000);

    // Full buffer, no terminator.
    fill_buf(32'h0000_4000, -1);
    run_job(32'h0000_4000, 2'd3, 0, 0, 0, 0, "full");
    check("full_lit_nchars", n_chars, 128);
    check("full_lit_reads", n_reads, 16);
    check("full_lit_busy", busy_cnt, 177);

    // First byte is a terminator.
    fill_buf(32'h0000_5000, -1);
    w_first_zero: begin
      logic [63:0] w0;
      w0 = mem[32'h0000_5000];
      w0[63:56] = 8'h00;
      mem[32'h0000_5000] = w0;
    end
    run_job(32'h0000_5000, 2'd0, 0, 0, 0, 0, "zero");
    check("zero_lit_nchars", n_chars, 0);
    check("zero_lit_reads", n_reads, 1);
    check("zero_lit_busy", busy_cnt, 20);

    // Consumer stalls for 5 cycles on the second character.
    fill_buf(32'h0000_6000, 20);
    stall_at = 2;
    run_job(32'h0000_6000, 2'd2, 0, 0, 0, 5, "stall");

    // Reset while word 3 is being read.
    base = 32'h0000_7000;
    fill_buf(base, -1);
    for (int i = 0; i < NW; i++) pre[i] = mem[base + 32'(i * 8)];
    build_model(base, m_cyc, m_nch, m_nrd);
    clear_counters();
    gmode = 0; rmode = 0; exp_core = 2'd1; done_allowed = 1;
    @(negedge clk);
    start_i = 1'b1; addr_i = base; core_id_i = 2'd1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (!(mem_req_o && !mem_write_o && mem_addr_o == base + 32'd24) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid_reached_word3", cyc < 500, 1);
    rst = 1'b1;
    exp_acc.delete(); exp_chars.delete(); done_allowed = 0;
    @(negedge clk);
    check_zero("rstmid");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_no_done", n_done, 0);
    check("rstmid_chars", n_chars, 24);
    for (int i = 0; i < NW; i++) begin
      a = base + 32'(i * 8);
      check("rstmid_word", mem_rd(a), (i < 3) ? 64'h0 : pre[i]);
    end
    fill_buf(base, $urandom_range(0, 127));
    run_job(base, 2'd3, 0, 0, 0, 0, "after_rst");

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1; addr_i = 32'h0000_9000;
    @(negedge clk);
    check("rst_start_busy", busy_o, 0);
    check("rst_start_req", mem_req_o, 0);
    rst = 1'b0; start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_still_idle", busy_o, 0);

    // Randomized buffers, addresses (including wrap), grant/ready patterns.
    for (int j = 0; j < 30; j++) begin
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      else a = $urandom;
      fill_buf(a & ~32'h7, ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 127)));
      run_job(a, 2'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1, 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/printf_fetch_engine.md
PRINTF_FETCH_ENGINE -- requirements
Module: printf_fetch_engine

Interface
REQ-001 Parameter NUM_WORDS, default 16: number of 64-bit buffer words fetched and cleared per request (128 bytes).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  single-cycle request to fetch one printf buffer.
REQ-005 addr_i  input  32  buffer base address, sampled with start_i.
REQ-006 core_id_i  input  2  originating core, sampled with start_i.
REQ-007 busy_o  output  1  high from the cycle after start acceptance until done_o is asserted, inclusive.
REQ-008 mem_req_o  output  1  memory access request.
REQ-009 mem_write_o  output  1  1 = write, 0 = read; valid while mem_req_o is high.
REQ-010 mem_addr_o  output  32  access address; bits [2:0] always 0.
REQ-011 mem_wdata_o  output  64  write data; always 0.
REQ-012 mem_mask_o  output  8  byte mask; 8'hFF on every write, don't-care on reads.
REQ-013 mem_gnt_i  input  1  access accepted when mem_req_o && mem_gnt_i.
REQ-014 mem_rdata_i  input  64  read data, valid exactly 1 cycle after an accepted read.
REQ-015 char_valid_o  output  1  character available.
REQ-016 char_data_o  output  8  character byte.
REQ-017 char_core_o  output  2  latched core_id for the current buffer.
REQ-018 char_ready_i  input  1  consumer accepts when char_valid_o && char_ready_i.
REQ-019 done_o  output  1  one-cycle pulse marking end of buffer processing.

Function
REQ-020 States: IDLE, RD_REQ, RD_WAIT, WR_CLR, EMIT, CLR_ONLY, DONE.
REQ-021 IDLE: start_i latches addr_i with [2:0] forced to 0, latches core_id_i, clears word index and terminator flag, and moves to RD_REQ; start_i in any other state is ignored.
REQ-022 RD_REQ: mem_req_o=1, mem_write_o=0, mem_addr_o=base+8*index; on grant, go to RD_WAIT.
REQ-023 RD_WAIT: capture mem_rdata_i into a 64-bit word register; go to WR_CLR.
REQ-024 WR_CLR: write 0 with mask 8'hFF to the same address; on grant, go to EMIT with byte index 0.
REQ-025 EMIT: present bytes MS-first, bits [63:56] first and [7:0] last; a byte equal to 8'h00, 8'h0A or 8'h0D sets the terminator flag and is not presented.
REQ-026 A presented byte holds char_data_o stable with char_valid_o high until accepted; valid never drops before acceptance.
REQ-027 Leaving EMIT after byte 7 or on terminator: if index==NUM_WORDS-1, go to DONE; otherwise increment index, then go to RD_REQ if no terminator has been seen, or to CLR_ONLY if one has.
REQ-028 CLR_ONLY: zero-write each remaining word without reading it, one granted write per word, and no characters; go to DONE after the last word.
REQ-029 DONE: done_o=1 for one cycle, then go to IDLE; busy_o falls with the return to IDLE.
REQ-030 If no terminator is found, all 8*NUM_WORDS bytes are presented.
REQ-031 Address arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFF8 is permitted and unflagged.
REQ-032 mem_req_o stays high with constant address and write until granted; no request is issued in IDLE, EMIT or DONE.
REQ-033 Throughput: with mem_gnt_i and char_ready_i held high, each fully read word takes 3 cycles plus one cycle per presented byte or terminator.

Reset
REQ-034 rst forces IDLE and drives all outputs to 0 (busy_o, mem_req_o, mem_write_o, mem_addr_o, mem_mask_o, char_valid_o, char_data_o, char_core_o, done_o) on the next posedge.
REQ-035 Reset mid-operation abandons the buffer: no further memory access, no done_o; words already cleared stay cleared.
REQ-036 rst takes priority over a simultaneous start_i.

Verification
REQ-037 Buffer at 0x8000_1000 = "Hi\n" followed by zeros, core_id 2, gnt and ready held high -> chars 'H','i' with char_core_o=2; done_o pulses; all 16 words read back 0; exactly 1 read, then 16 writes total.
REQ-038 start_i with addr_i=0x8000_1005 -> first access address 0x8000_1000.
REQ-039 128 nonzero non-terminator bytes -> exactly 128 chars; 16 reads and 16 writes; done_o pulses once.
REQ-040 First byte 8'h00 -> zero chars; done_o still pulses; 1 read and 16 writes.
REQ-041 char_ready_i low for 5 cycles on the 2nd char -> char_data_o stable and char_valid_o high throughout; no char lost or duplicated.
REQ-042 rst asserted during the word-3 read -> outputs 0 next cycle; no done_o; words 0-2 zero, words 3-15 unchanged; a new start_i then works normally.
